// File: rtl/uart_tx_core_if.sv
// Transmit request/status bundle between the local controller (master) and uart_tx_core (slave).
// Carries the request, the byte to send, the completion pulse, the busy flag and the serial line.
interface uart_tx_core_if;
    logic       TX_En_Sig;
    logic [7:0] TX_Data;
    logic       TX_Done_Sig;
    logic       TX_Busy;
    logic       TX_Pin_Out;

    modport master (
        output TX_En_Sig,
        output TX_Data,
        input  TX_Done_Sig,
        input  TX_Busy,
        input  TX_Pin_Out
    );

    modport slave (
        input  TX_En_Sig,
        input  TX_Data,
        output TX_Done_Sig,
        output TX_Busy,
        output TX_Pin_Out
    );
endinterface

// File: rtl/uart_tx_core.sv
// Byte-serial UART transmitter (8N1) with an integrated baud counter; every bit lasts BPS_DIV cycles.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit (8E1).
module uart_tx_core #(
    parameter int unsigned BPS_DIV = 434
) (
    input  logic           CLK,
    input  logic           RSTn,
    uart_tx_core_if.slave  tx_if
);

    localparam logic [15:0] BAUD_LAST = 16'(BPS_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_pin;
    logic        w_pin_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;
    logic        w_bit_end;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed during DATA, so parity is latched with the byte.
    logic        r_parity;
    logic        w_parity_next;
`endif

    assign w_bit_end = (r_state != IDLE) && (r_baud_cnt == BAUD_LAST);

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_pin      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_pin      <= w_pin_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (tx_if.TX_En_Sig) w_state_next = START;
            START: if (w_bit_end) w_state_next = DATA;
            DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_bit_end) w_state_next = STOP;
`endif
            STOP:  if (w_bit_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output and datapath next values; the pin only moves on accept or bit-end.
    always_comb begin
        w_baud_cnt_next = '0;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_pin_next      = r_pin;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next   = r_parity;
`endif

        if (r_state != IDLE && !w_bit_end) begin
            w_baud_cnt_next = r_baud_cnt + 16'd1;
        end

        case (r_state)
            IDLE: begin
                w_pin_next = 1'b1;
                if (tx_if.TX_En_Sig) begin
                    w_shift_next  = tx_if.TX_Data;
                    w_pin_next    = 1'b0;
                    w_busy_next   = 1'b1;
                    w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = ^tx_if.TX_Data;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_pin_next   = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_pin_next     = r_parity;
`else
                        w_pin_next     = 1'b1;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_pin_next     = r_shift[0];
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) w_pin_next = 1'b1;
            end
`endif
            STOP: begin
                w_pin_next = 1'b1;
                if (w_bit_end) begin
                    w_busy_next = 1'b0;
                    w_done_next = 1'b1;
                end
            end
            default: begin
                w_pin_next  = 1'b1;
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign tx_if.TX_Pin_Out  = r_pin;
    assign tx_if.TX_Busy     = r_busy;
    assign tx_if.TX_Done_Sig = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at BPS_DIV=4: table of single frames plus back-to-back and mid-frame reset sequences.
// Honours UART_TX_PARITY_EN so the same bench covers the 8N1 and 8E1 builds.
module tb_uart_tx_core;

    localparam int BPS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic CLK = 1'b0;
    logic RSTn;
    int   n_pass   = 0;
    int   n_total  = 0;
    int   done_cnt = 0;

    uart_tx_core_if tx_if ();

    uart_tx_core #(.BPS_DIV(BPS)) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .tx_if (tx_if)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (tx_if.TX_Done_Sig === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] data_after;
        logic [7:0] exp_line;
        logic       exp_par;
        string      name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    function automatic logic [10:0] build_frame(input logic [7:0] bits, input logic par);
        logic [10:0] f;
        f       = '1;
        f[0]    = 1'b0;
        f[8:1]  = bits;
`ifdef UART_TX_PARITY_EN
        f[9]    = par;
`else
        f[9]    = 1'b1;
        if (par) f[10] = 1'b1;
`endif
        return f;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [7:0] da,
                              input logic [10:0] exp_f, input string nm);
        logic [10:0] got;
        int glitches, busy_bad, done_bad, d0;
        @(negedge CLK);
        tx_if.TX_En_Sig = 1'b1;
        tx_if.TX_Data   = d;
        @(negedge CLK);
        tx_if.TX_En_Sig = 1'b0;
        tx_if.TX_Data   = da;
        d0 = done_cnt;
        got = '0; glitches = 0; busy_bad = 0; done_bad = 0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < BPS; c++) begin
                if (c == 0) got[b] = tx_if.TX_Pin_Out;
                else if (tx_if.TX_Pin_Out !== got[b]) glitches++;
                if (tx_if.TX_Busy !== 1'b1) busy_bad++;
                if (tx_if.TX_Done_Sig !== 1'b0) done_bad++;
                @(negedge CLK);
            end
        end
        for (int b = 0; b < NB; b++)
            check($sformatf("%s bit%0d", nm, b), 32'(got[b]), 32'(exp_f[b]));
        check({nm, " glitches"}, glitches, 0);
        check({nm, " busy_in_frame_low"}, busy_bad, 0);
        check({nm, " early_done"}, done_bad, 0);
        check({nm, " done_at_end"}, 32'(tx_if.TX_Done_Sig), 1);
        check({nm, " busy_in_done"}, 32'(tx_if.TX_Busy), 0);
        check({nm, " pin_in_done"}, 32'(tx_if.TX_Pin_Out), 1);
        @(negedge CLK);
        check({nm, " done_one_cycle"}, 32'(tx_if.TX_Done_Sig), 0);
        check({nm, " done_count"}, done_cnt - d0, 1);
    endtask

    // Samples one bit per bit period (second cycle of each bit); drops the request at a given cycle.
    task automatic capture(output logic [10:0] f, input int drop_en_at);
        f = '1;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < BPS; c++) begin
                if (b * BPS + c == drop_en_at) tx_if.TX_En_Sig = 1'b0;
                if (c == 1) f[b] = tx_if.TX_Pin_Out;
                @(negedge CLK);
            end
        end
    endtask

    vec_t        vecs [7];
    logic [10:0] f1, f2;
    int          d0;

    initial begin
        vecs[0] = '{8'h55, 8'h55, 8'b0101_0101, 1'b0, "tx55"};
        vecs[1] = '{8'hA3, 8'hFF, 8'b1010_0011, 1'b0, "txA3_chg"};
        vecs[2] = '{8'h07, 8'h00, 8'b0000_0111, 1'b1, "tx07"};
        vecs[3] = '{8'h03, 8'h03, 8'b0000_0011, 1'b0, "tx03"};
        vecs[4] = '{8'h00, 8'hFF, 8'b0000_0000, 1'b0, "tx00"};
        vecs[5] = '{8'hFF, 8'h00, 8'b1111_1111, 1'b0, "txFF"};
        vecs[6] = '{8'h80, 8'h80, 8'b1000_0000, 1'b1, "tx80"};

        RSTn = 1'b0;
        tx_if.TX_En_Sig = 1'b0;
        tx_if.TX_Data   = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset pin", 32'(tx_if.TX_Pin_Out), 1);
        check("reset busy", 32'(tx_if.TX_Busy), 0);
        check("reset done", 32'(tx_if.TX_Done_Sig), 0);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle pin", 32'(tx_if.TX_Pin_Out), 1);
        check("idle busy", 32'(tx_if.TX_Busy), 0);

        for (int i = 0; i < 7; i++)
            send_frame(vecs[i].data, vecs[i].data_after,
                       build_frame(vecs[i].exp_line, vecs[i].exp_par), vecs[i].name);

        // Back-to-back: request held high; second frame starts right after the Done cycle.
        @(negedge CLK);
        tx_if.TX_En_Sig = 1'b1;
        tx_if.TX_Data   = 8'h01;
        @(negedge CLK);
        tx_if.TX_Data   = 8'h80;
        d0 = done_cnt;
        capture(f1, -1);
        check("b2b done1", 32'(tx_if.TX_Done_Sig), 1);
        check("b2b done1 count", done_cnt - d0, 1);
        @(negedge CLK);
        check("b2b no gap start", 32'(tx_if.TX_Pin_Out), 0);
        capture(f2, 2);
        check("b2b done2", 32'(tx_if.TX_Done_Sig), 1);
        check("b2b busy2", 32'(tx_if.TX_Busy), 0);
        check("b2b frame1", 32'(f1), 32'(build_frame(8'b0000_0001, 1'b1)));
        check("b2b frame2", 32'(f2), 32'(build_frame(8'b1000_0000, 1'b1)));
        @(negedge CLK);
        check("b2b done count", done_cnt - d0, 2);
        check("b2b idle after", 32'(tx_if.TX_Busy), 0);

        // Reset during data bit 3 of 0x0F (cycles k+17..k+20).
        @(negedge CLK);
        tx_if.TX_En_Sig = 1'b1;
        tx_if.TX_Data   = 8'h0F;
        @(negedge CLK);
        tx_if.TX_En_Sig = 1'b0;
        d0 = done_cnt;
        repeat (17) @(negedge CLK);
        check("rst mid busy before", 32'(tx_if.TX_Busy), 1);
        RSTn = 1'b0;
        #1;
        check("rst async pin", 32'(tx_if.TX_Pin_Out), 1);
        check("rst async busy", 32'(tx_if.TX_Busy), 0);
        check("rst async done", 32'(tx_if.TX_Done_Sig), 0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (NB * BPS + 5) @(negedge CLK);
        check("rst no done", done_cnt - d0, 0);
        check("rst idle pin", 32'(tx_if.TX_Pin_Out), 1);
        send_frame(8'h0F, 8'h0F, build_frame(8'b0000_1111, 1'b0), "post_rst0F");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
